// File: rtl/timeout_scanner_if.sv
// Bundle between the send/ack paths (arm/disarm), the timeout scanner and the
// downstream timeout-event consumer.
interface timeout_scanner_if #(
  parameter int FLOW_ID_W = 4,
  parameter int TIMER_W   = 16
);
  logic                 arm_valid;
  logic [FLOW_ID_W-1:0] arm_fid;
  logic [TIMER_W-1:0]   arm_amnt;
  logic                 disarm_valid;
  logic [FLOW_ID_W-1:0] disarm_fid;
  logic                 to_valid;
  logic [FLOW_ID_W-1:0] to_fid;
  logic                 to_ready;
  logic [TIMER_W-1:0]   now;

  modport master (
    output arm_valid, arm_fid, arm_amnt, disarm_valid, disarm_fid, to_ready,
    input  to_valid, to_fid, now
  );

  modport slave (
    input  arm_valid, arm_fid, arm_amnt, disarm_valid, disarm_fid, to_ready,
    output to_valid, to_fid, now
  );
endinterface

// File: rtl/timeout_scanner.sv
// Per-flow retransmission deadline table swept one flow per cycle against a
// free-running time base; expired flows are reported once over valid/ready.
module timeout_scanner #(
  parameter int FLOW_NUM  = 16,
  parameter int FLOW_ID_W = 4,
  parameter int TIMER_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  timeout_scanner_if.slave bus
);
  logic [TIMER_W-1:0]   now_r;
  logic [FLOW_ID_W-1:0] ptr_r;
  logic [FLOW_NUM-1:0]  armed_r;
  logic [FLOW_NUM-1:0]  armed_nxt_s;
  logic [TIMER_W-1:0]   deadline_r [FLOW_NUM];
  logic                 to_valid_r;
  logic [FLOW_ID_W-1:0] to_fid_r;
  logic                 stall_s;
  logic                 hit_s;
  logic                 expired_s;
  logic                 fire_s;
  logic [TIMER_W-1:0]   arm_deadline_s;

  // Wrap-safe "deadline reached": signed (t - dl) is non-negative.
  function automatic logic is_expired(input logic [TIMER_W-1:0] t,
                                      input logic [TIMER_W-1:0] dl);
    logic [TIMER_W-1:0] diff;
    diff = t - dl;
    return ~diff[TIMER_W-1];
  endfunction

  // Evaluate the flow under the scan pointer; a same-cycle arm/disarm on it suppresses the event.
  always_comb begin
    stall_s        = to_valid_r && !bus.to_ready;
    hit_s          = (bus.arm_valid && (bus.arm_fid == ptr_r)) ||
                     (bus.disarm_valid && (bus.disarm_fid == ptr_r));
    expired_s      = armed_r[ptr_r] && is_expired(now_r, deadline_r[ptr_r]);
    fire_s         = !stall_s && expired_s && !hit_s;
    arm_deadline_s = now_r + bus.arm_amnt;
  end

  // Next armed bits: arm beats disarm, both beat the one-shot clear of a fired flow.
  always_comb begin
    armed_nxt_s = armed_r;
    for (int f = 0; f < FLOW_NUM; f++) begin
      if (bus.arm_valid && (bus.arm_fid == FLOW_ID_W'(f))) begin
        armed_nxt_s[f] = 1'b1;
      end else if (bus.disarm_valid && (bus.disarm_fid == FLOW_ID_W'(f))) begin
        armed_nxt_s[f] = 1'b0;
      end else if (fire_s && (ptr_r == FLOW_ID_W'(f))) begin
        armed_nxt_s[f] = 1'b0;
      end else begin
        armed_nxt_s[f] = armed_r[f];
      end
    end
  end

  // Time base, scan pointer, armed bits and the event output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      now_r      <= '0;
      ptr_r      <= '0;
      armed_r    <= '0;
      to_valid_r <= 1'b0;
      to_fid_r   <= '0;
    end else begin
      now_r   <= now_r + TIMER_W'(1);
      armed_r <= armed_nxt_s;
      if (!stall_s) begin
        ptr_r      <= ptr_r + FLOW_ID_W'(1);
        to_valid_r <= fire_s;
        if (fire_s) begin
          to_fid_r <= ptr_r;
        end
      end
    end
  end

  // Deadlines are qualified by armed bits, so they need no reset.
  always_ff @(posedge clk) begin
    if (bus.arm_valid) begin
      deadline_r[bus.arm_fid] <= arm_deadline_s;
    end
  end

  assign bus.to_valid = to_valid_r;
  assign bus.to_fid   = to_fid_r;
  assign bus.now      = now_r;
endmodule

// File: tb/tb_timeout_scanner.sv
// Bench for timeout_scanner: integer-arithmetic reference model checked every
// cycle, directed scenarios pinning the model, then randomized traffic.
module tb_timeout_scanner;
  localparam int FLOW_NUM  = 16;
  localparam int FLOW_ID_W = 4;
  localparam int TIMER_W   = 16;
  localparam int TMOD      = 65536;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timeout_scanner_if #(.FLOW_ID_W(FLOW_ID_W), .TIMER_W(TIMER_W)) bus ();

  timeout_scanner #(.FLOW_NUM(FLOW_NUM), .FLOW_ID_W(FLOW_ID_W), .TIMER_W(TIMER_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_print = 0;
  bit chk_en  = 1'b0;

  // Reference state: time, scan position, flow table, output register.
  int m_now = 0, m_ptr = 0, m_tv = 0, m_tf = 0;
  int m_armed [FLOW_NUM];
  int m_dl    [FLOW_NUM];
  int m_loads = 0, m_load_now = -1, m_load_fid = -1;
  int mf, mdiff;
  bit mstall, mhit, mexp;

  always @(posedge clk) begin
    if (rst) begin
      m_now = 0; m_ptr = 0; m_tv = 0; m_tf = 0;
      for (int i = 0; i < FLOW_NUM; i++) m_armed[i] = 0;
    end else begin
      mstall = (m_tv != 0) && !bus.to_ready;
      if (!mstall) begin
        mf    = m_ptr;
        mdiff = ((m_now - m_dl[mf]) % TMOD + TMOD) % TMOD;
        mexp  = (m_armed[mf] != 0) && (mdiff < TMOD / 2);
        mhit  = (bus.arm_valid && int'(bus.arm_fid) == mf) ||
                (bus.disarm_valid && int'(bus.disarm_fid) == mf);
        if (mexp && !mhit) begin
          m_tv = 1; m_tf = mf; m_armed[mf] = 0;
          m_loads++; m_load_now = (m_now + 1) % TMOD; m_load_fid = mf;
        end else begin
          m_tv = 0;
        end
        m_ptr = (m_ptr + 1) % FLOW_NUM;
      end
      if (bus.disarm_valid) m_armed[int'(bus.disarm_fid)] = 0;
      if (bus.arm_valid) begin
        m_armed[int'(bus.arm_fid)] = 1;
        m_dl[int'(bus.arm_fid)]    = (m_now + int'(bus.arm_amnt)) % TMOD;
      end
      m_now = (m_now + 1) % TMOD;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (int'(bus.now) != m_now || bus.to_valid !== (m_tv != 0) || int'(bus.to_fid) != m_tf
          || $isunknown({bus.now, bus.to_valid, bus.to_fid})) begin
        n_fail++;
        if (n_print < 40) begin
          n_print++;
          $display("FAIL cycle_cmp: dut now=%0d valid=%0b fid=%0d, model now=%0d valid=%0d fid=%0d",
                   bus.now, bus.to_valid, bus.to_fid, m_now, m_tv, m_tf);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.arm_valid = 1'b0; bus.arm_fid = '0; bus.arm_amnt = 16'd1;
    bus.disarm_valid = 1'b0; bus.disarm_fid = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic run_to(input int t);
    for (int i = 0; i < 70000; i++) begin
      if (m_now == t) return;
      step();
    end
    check("run_to_timeout", m_now, t);
  endtask

  task automatic arm(input int fid, input int amnt);
    bus.arm_valid = 1'b1; bus.arm_fid = FLOW_ID_W'(fid); bus.arm_amnt = TIMER_W'(amnt);
    step();
    bus.arm_valid = 1'b0;
  endtask

  task automatic disarm(input int fid);
    bus.disarm_valid = 1'b1; bus.disarm_fid = FLOW_ID_W'(fid);
    step();
    bus.disarm_valid = 1'b0;
  endtask

  int base;

  initial begin
    bus.to_ready = 1'b1;
    do_reset();
    check("reset_now", m_now, 0);
    check("reset_valid", m_tv, 0);

    // Basic expiry: deadline 50 -> event visible at now=52.
    base = m_loads;
    run_to(10); arm(3, 40);
    run_to(200);
    check("basic_count", m_loads - base, 1);
    check("basic_now", m_load_now, 52);
    check("basic_fid", m_load_fid, 3);

    // Disarm, then simultaneous arm+disarm where arm wins.
    do_reset();
    base = m_loads;
    arm(5, 100);
    run_to(60); disarm(5);
    run_to(400);
    check("disarm_quiet", m_loads - base, 0);
    bus.disarm_valid = 1'b1; bus.disarm_fid = 4'd5;
    arm(5, 20);
    bus.disarm_valid = 1'b0;
    run_to(500);
    check("armdis_count", m_loads - base, 1);
    check("armdis_now", m_load_now, 422);
    check("armdis_fid", m_load_fid, 5);

    // Backpressure: fid 2 held from 19 to 40, then fid 4 follows.
    do_reset();
    base = m_loads;
    bus.to_ready = 1'b0;
    arm(2, 8); arm(4, 7);
    run_to(39);
    check("bp_valid_held", m_tv, 1);
    check("bp_fid_held", m_tf, 2);
    check("bp_first_now", m_load_now, 19);
    run_to(40); bus.to_ready = 1'b1;
    run_to(120);
    check("bp_count", m_loads - base, 2);
    check("bp_second_now", m_load_now, 42);
    check("bp_second_fid", m_load_fid, 4);

    // Wrap-around: deadline 14 after the time base wraps.
    do_reset();
    run_to(65530);
    base = m_loads;
    arm(14, 20);
    run_to(100);
    check("wrap_count", m_loads - base, 1);
    check("wrap_now", m_load_now, 15);
    check("wrap_fid", m_load_fid, 14);

    // Race: re-arm on the very cycle the pointer finds the flow expired.
    do_reset();
    base = m_loads;
    arm(7, 10);
    run_to(23); arm(7, 30);
    run_to(120);
    check("race_count", m_loads - base, 1);
    check("race_now", m_load_now, 56);
    check("race_fid", m_load_fid, 7);

    // Reset with an event pending and flows armed.
    do_reset();
    bus.to_ready = 1'b0;
    arm(1, 5); arm(2, 5); arm(3, 5);
    run_to(30);
    check("rstmid_pending", m_tv, 1);
    rst = 1'b1; step(); rst = 1'b0;
    check("rstmid_now", m_now, 0);
    check("rstmid_valid", m_tv, 0);
    bus.to_ready = 1'b1;
    base = m_loads;
    repeat (200) step();
    check("rstmid_quiet", m_loads - base, 0);

    // Randomized traffic, checked cycle by cycle against the model.
    do_reset();
    base = m_loads;
    for (int i = 0; i < 4000; i++) begin
      bus.arm_valid = ($urandom_range(0, 3) == 0);
      bus.arm_fid   = FLOW_ID_W'($urandom_range(0, FLOW_NUM - 1));
      if ($urandom_range(0, 5) == 0) bus.arm_fid = FLOW_ID_W'(m_ptr);
      bus.arm_amnt  = ($urandom_range(0, 9) == 0) ? TIMER_W'($urandom_range(1, 32767))
                                                   : TIMER_W'($urandom_range(1, 80));
      bus.disarm_valid = ($urandom_range(0, 7) == 0);
      bus.disarm_fid   = ($urandom_range(0, 3) == 0) ? bus.arm_fid
                                                     : FLOW_ID_W'($urandom_range(0, FLOW_NUM - 1));
      bus.to_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();
    n_tests++;
    if (m_loads - base < 20) begin
      n_fail++;
      $display("FAIL random_activity: got %0d events, expected at least 20", m_loads - base);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
